// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: instruction handshake and registered control bundle of the decode stage.
interface ctrl_seq_if #(parameter int OPW = 4);
  logic [8:0] instr;
  logic instr_valid;
  logic instr_ready;
  logic flush;
  logic ctl_valid;
  logic truncated_reg;
  logic trunc_prefix;
  logic abs_branch;
  logic rel_branch;
  logic branch_invert;
  logic branch_flag;
  logic mem_write;
  logic reg_write;
  logic mem_to_reg;
  logic [1:0] second_operand;
  logic [OPW-1:0] alu_op;
  logic halted;
  logic illegal_op;
  modport master (
    output instr, instr_valid, flush,
    input instr_ready, ctl_valid, truncated_reg, trunc_prefix, abs_branch, rel_branch,
          branch_invert, branch_flag, mem_write, reg_write, mem_to_reg, second_operand,
          alu_op, halted, illegal_op
  );
  modport slave (
    input instr, instr_valid, flush,
    output instr_ready, ctl_valid, truncated_reg, trunc_prefix, abs_branch, rel_branch,
           branch_invert, branch_flag, mem_write, reg_write, mem_to_reg, second_operand,
           alu_op, halted, illegal_op
  );
endinterface

// File: rtl/ctrl_seq.sv
// ctrl_seq: registered instruction decoder with memory wait states, flush squash and sticky halt.
module ctrl_seq #(
  parameter int OPW = 4,
  parameter int MEM_LAT = 2
) (
  input logic clk,
  input logic reset,
  ctrl_seq_if.slave bus
);
  typedef enum logic [1:0] {RUN, MEM, HALT} state_t;
  typedef struct packed {
    logic trunc_reg;
    logic trunc_prefix;
    logic abs_br;
    logic rel_br;
    logic br_inv;
    logic br_flag;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic [1:0] sec_op;
    logic [2:0] alu_op;
  } ctl_t;
  localparam bit STALL = MEM_LAT > 1;
  state_t state, nxt;
  logic [3:0] cnt;
  ctl_t d, q;
  logic d_illegal, accept;
  logic [2:0] opc;
  assign opc = bus.instr[8:6];
  assign bus.instr_ready = (state == RUN) & ~bus.flush & ~reset;
  assign accept = bus.instr_valid & bus.instr_ready;
  always_comb begin
    d = '0;
    d.reg_write = 1'b1;
    d.sec_op = 2'b01;
    d_illegal = 1'b0;
    case (opc)
      3'd1: d.alu_op = 3'd1;
      3'd2: d.alu_op = 3'd2;
      3'd3: begin
        d.alu_op = 3'd1;
        d.trunc_reg = 1'b1;
        d.sec_op = 2'b00;
        d.mem_to_reg = ~bus.instr[3];
        d.mem_write = bus.instr[3];
        d.reg_write = ~bus.instr[3];
      end
      3'd4: begin
        d.trunc_reg = 1'b1;
        d.trunc_prefix = 1'b1;
        d.sec_op = 2'b10;
      end
      3'd5: begin
        d.alu_op = bus.instr[2:0] == 3'b000 ? 3'd4 :
                   bus.instr[2:0] == 3'b010 ? 3'd5 :
                   bus.instr[2:0] == 3'b011 ? 3'd3 :
                   bus.instr[2:0] == 3'b100 ? 3'd6 :
                   bus.instr[2:0] == 3'b110 ? 3'd7 : 3'd0;
        d_illegal = bus.instr[0] & (bus.instr[2] | ~bus.instr[1]);
        d.reg_write = ~d_illegal;
      end
      3'd6: begin
        d.reg_write = 1'b0;
        d.abs_br = bus.instr[0];
        d.rel_br = ~bus.instr[0];
        d.br_flag = bus.instr[1];
        d.br_inv = bus.instr[2];
      end
      3'd7: begin
        d.reg_write = 1'b0;
        d.sec_op = 2'b00;
      end
      default: ;
    endcase
  end
  always_comb begin
    nxt = state;
    case (state)
      RUN: nxt = accept & STALL & (opc == 3'd3) ? MEM :
                 accept & (opc == 3'd7) ? HALT : RUN;
      MEM: nxt = cnt == 4'd1 ? RUN : MEM;
      default: nxt = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      q <= '0;
      bus.ctl_valid <= 1'b0;
      bus.illegal_op <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (state == RUN) & (nxt == MEM) ? 4'(MEM_LAT - 1) :
             state == MEM ? cnt - 4'd1 : cnt;
      if (accept) q <= d;
      bus.ctl_valid <= accept;
      bus.illegal_op <= accept & d_illegal;
    end
  end
  assign bus.truncated_reg = q.trunc_reg;
  assign bus.trunc_prefix = q.trunc_prefix;
  assign bus.abs_branch = q.abs_br;
  assign bus.rel_branch = q.rel_br;
  assign bus.branch_invert = q.br_inv;
  assign bus.branch_flag = q.br_flag;
  assign bus.mem_write = q.mem_write;
  assign bus.reg_write = q.reg_write;
  assign bus.mem_to_reg = q.mem_to_reg;
  assign bus.second_operand = q.sec_op;
  assign bus.alu_op = OPW'(q.alu_op);
  assign bus.halted = state == HALT;
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed sequence with a scoreboard of expected control bundles and issue cycles.
module tb_ctrl_seq;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {
    int c;
    logic [15:0] v;
  } exp_t;
  exp_t sb[$];
  ctrl_seq_if #(.OPW(4)) bus ();
  ctrl_seq #(.OPW(4), .MEM_LAT(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [15:0] model(input logic [8:0] i);
    logic tr, tp, ab, rb, bi, bf, mw, rw, mr, il;
    logic [1:0] so;
    logic [3:0] op;
    {tr, tp, ab, rb, bi, bf, mw, mr, il} = '0;
    rw = 1'b1;
    so = 2'b01;
    op = 4'd0;
    case (i[8:6])
      3'b001: op = 4'd1;
      3'b010: op = 4'd2;
      3'b011: begin
        op = 4'd1; tr = 1'b1; so = 2'b00;
        if (i[3]) begin mw = 1'b1; rw = 1'b0; end else mr = 1'b1;
      end
      3'b100: begin tr = 1'b1; tp = 1'b1; so = 2'b10; end
      3'b101: case (i[2:0])
        3'b000: op = 4'd4;
        3'b010: op = 4'd5;
        3'b011: op = 4'd3;
        3'b100: op = 4'd6;
        3'b110: op = 4'd7;
        default: begin rw = 1'b0; il = 1'b1; end
      endcase
      3'b110: begin rw = 1'b0; ab = i[0]; rb = ~i[0]; bf = i[1]; bi = i[2]; end
      3'b111: begin rw = 1'b0; so = 2'b00; end
      default: ;
    endcase
    return {tr, tp, ab, rb, bi, bf, mw, rw, mr, so, op, il};
  endfunction
  function automatic logic [15:0] obs();
    return {bus.truncated_reg, bus.trunc_prefix, bus.abs_branch, bus.rel_branch,
            bus.branch_invert, bus.branch_flag, bus.mem_write, bus.reg_write,
            bus.mem_to_reg, bus.second_operand, bus.alu_op, bus.illegal_op};
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.ctl_valid === 1'b1) begin
      chk("unexpected_ctl_valid", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("issue_cycle", cyc, e.c);
        chk("ctl_bundle", 32'(obs()), 32'(e.v));
      end
    end else chk("illegal_without_valid", 32'(bus.illegal_op), 32'd0);
  endtask
  task automatic send(input logic [8:0] i);
    int n = 0;
    bus.instr = i;
    bus.instr_valid = 1'b1;
    #1;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk("accept_timeout", 32'(bus.instr_ready), 32'd1);
    if (bus.instr_ready === 1'b1) sb.push_back('{cyc + 1, model(i)});
    tick();
    bus.instr_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    bus.instr = '0;
    bus.instr_valid = 1'b1;
    bus.flush = 1'b0;
    tick();
    #1 chk("ready_in_reset", 32'(bus.instr_ready), 32'd0);
    tick();
    chk("reset_ctl", 32'(obs()), 32'd0);
    chk("reset_valid", 32'(bus.ctl_valid), 32'd0);
    chk("reset_halted", 32'(bus.halted), 32'd0);
    bus.instr_valid = 1'b0;
    reset = 1'b0;
    send(9'b000_000_001);
    send(9'b001_000_000);
    send(9'b010_000_000);
    send(9'b100_000_111);
    send(9'b011_000_000);
    bus.instr = 9'b000_000_001;
    bus.instr_valid = 1'b1;
    #1 chk("mem_stall1", 32'(bus.instr_ready), 32'd0);
    tick();
    #1 chk("mem_stall2", 32'(bus.instr_ready), 32'd0);
    chk("lod_held_memtoreg", 32'(bus.mem_to_reg), 32'd1);
    tick();
    #1 chk("mem_done_ready", 32'(bus.instr_ready), 32'd1);
    send(9'b000_000_001);
    send(9'b011_001_000);
    send(9'b110_000_111);
    bus.instr = 9'b000_000_001;
    bus.instr_valid = 1'b1;
    bus.flush = 1'b1;
    #1 chk("flush_ready", 32'(bus.instr_ready), 32'd0);
    tick();
    chk("flush_no_issue", 32'(bus.ctl_valid), 32'd0);
    chk("flush_ctl_held", 32'(bus.abs_branch), 32'd1);
    bus.flush = 1'b0;
    send(9'b000_000_001);
    send(9'b101_000_101);
    send(9'b101_000_011);
    send(9'b111_000_000);
    bus.instr = 9'b000_000_001;
    bus.instr_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.flush = 1'(k & 1);
      #1;
      chk("halted_sticky", 32'(bus.halted), 32'd1);
      chk("halt_ready", 32'(bus.instr_ready), 32'd0);
      tick();
    end
    bus.flush = 1'b0;
    bus.instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("halt_cleared", 32'(bus.halted), 32'd0);
    reset = 1'b0;
    #1 chk("ready_after_reset", 32'(bus.instr_ready), 32'd1);
    tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
